// File: rtl/multi_tick_gen_pkg.sv
// multi_tick_gen_pkg
//   Shared defaults and helpers for the multi-channel tick generator.
//   PKG_F_PCK : default PCK frequency in Hz
//   PKG_DIV_W : default divisor/counter width in bits
//   PKG_N_CH  : default number of channels
//   half_div  : half-period divisor (count minus 1) for a wanted output rate
//   ch_width  : width of the channel-select field for a channel count
package multi_tick_gen_pkg;

  localparam int unsigned PKG_F_PCK = 25174825;
  localparam int          PKG_DIV_W = 32;
  localparam int          PKG_N_CH  = 4;

  function automatic int unsigned half_div(input int unsigned f_pck,
                                           input int unsigned f_out);
    return f_pck / (2 * f_out) - 1;
  endfunction

  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/multi_tick_gen_if.sv
// multi_tick_gen_if
//   Divisor-update request channel.
//   LD_VALID : requester has a divisor update on LD_CH/LD_DIV
//   LD_READY : responder can take it
//   LD_CH    : target channel
//   LD_DIV   : new half-period count minus 1
//   Handshake: an update transfers on a PCK rising edge where LD_VALID and
//   LD_READY are both high. LD_READY may depend combinationally on LD_CH;
//   the requester holds LD_CH/LD_DIV stable while LD_VALID waits.
interface multi_tick_gen_if
  import multi_tick_gen_pkg::*;
#(
  parameter int N_CH  = PKG_N_CH,
  parameter int DIV_W = PKG_DIV_W
);
  localparam int CH_W = ch_width(N_CH);

  logic             LD_VALID;
  logic             LD_READY;
  logic [CH_W-1:0]  LD_CH;
  logic [DIV_W-1:0] LD_DIV;

  modport master (output LD_VALID, output LD_CH, output LD_DIV, input LD_READY);
  modport slave  (input LD_VALID, input LD_CH, input LD_DIV, output LD_READY);

endinterface

// File: rtl/tick_gen_ch.sv
// tick_gen_ch
//   One divider channel: counter C, active divisor D, pending divisor P with
//   flag F, square-wave output and rising-edge tick.
//   Optional: MULTI_TICK_GEN_SYNC_EN adds sync_i (phase-align pulse).
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : run enable (low freezes everything)
//   ld_i         : accepted update for this channel, ld_div_i is the value
//   clk_o        : 50% square wave, half period D+1 cycles
//   tick_o       : high in the cycle clk_o is newly 1
//   pend_o       : pending divisor waiting for the next terminal count
module tick_gen_ch #(
  parameter int               DIV_W   = 32,
  parameter logic [DIV_W-1:0] RST_DIV = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef MULTI_TICK_GEN_SYNC_EN
  input  logic             sync_i,
`endif
  input  logic             en_i,
  input  logic             ld_i,
  input  logic [DIV_W-1:0] ld_div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pend_o
);

  logic [DIV_W-1:0] c_q = '0;
  logic [DIV_W-1:0] d_q = RST_DIV;
  logic [DIV_W-1:0] p_q = '0;
  logic             f_q = 1'b0;
  logic             clk_q = 1'b0;
  logic             tick_q = 1'b0;

  logic [DIV_W-1:0] c_d, d_d, p_d;
  logic             f_d, clk_d, tick_d;
  logic             tc;

  // Equality only: a counter above D simply wraps around to reach D.
  assign tc = (c_q == d_q);

  always_comb begin
    c_d    = c_q;
    d_d    = d_q;
    p_d    = p_q;
    f_d    = f_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (en_i) begin
      if (tc) begin
        c_d    = '0;
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
        // Only an update accepted in an earlier cycle is applied here, so
        // the half-period that just ended always used the old divisor.
        if (f_q) begin
          d_d = p_q;
          f_d = 1'b0;
        end
      end else begin
        c_d = c_q + DIV_W'(1);
      end
    end
`ifdef MULTI_TICK_GEN_SYNC_EN
    if (sync_i) begin
      c_d    = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      if (f_q) begin
        d_d = p_q;
        f_d = 1'b0;
      end
    end
`endif
    // ld_i can only arrive while f_q is clear, so it never collides with
    // the apply paths above.
    if (ld_i) begin
      p_d = ld_div_i;
      f_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_q    <= '0;
      d_q    <= RST_DIV;
      p_q    <= '0;
      f_q    <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      d_q    <= d_d;
      p_q    <= p_d;
      f_q    <= f_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign pend_o = f_q;

endmodule

// File: rtl/multi_tick_gen.sv
// multi_tick_gen
//   N_CH independent programmable square-wave/tick generators on PCK.
//   Optional: MULTI_TICK_GEN_SYNC_EN adds input SYNC which zeroes every
//   counter and output and applies pending divisors (phase alignment).
//   PCK     : clock          RST : synchronous active-high reset
//   EN      : per-channel run enable
//   ld      : divisor-update handshake (slave side)
//   CLK_OUT : per-channel square wave   TICK : per-channel rising-edge pulse
module multi_tick_gen
  import multi_tick_gen_pkg::*;
#(
  parameter int unsigned F_PCK = PKG_F_PCK,
  parameter int          N_CH  = PKG_N_CH,
  parameter int          DIV_W = PKG_DIV_W
) (
  input  logic              PCK,
  input  logic              RST,
`ifdef MULTI_TICK_GEN_SYNC_EN
  input  logic              SYNC,
`endif
  input  logic [N_CH-1:0]   EN,
  multi_tick_gen_if.slave   ld,
  output logic [N_CH-1:0]   CLK_OUT,
  output logic [N_CH-1:0]   TICK
);

  localparam int               CH_W    = ch_width(N_CH);
  // Reset rate is 1 Hz.
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(half_div(F_PCK, 1));

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] ld_sel;
  logic            ready;
  logic            accept;

  // Out-of-range channel numbers match nothing: always ready, discarded.
  always_comb begin
    ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (pend[i] && (ld.LD_CH == CH_W'(i))) ready = 1'b0;
    end
  end

  assign accept      = ld.LD_VALID & ready;
  assign ld.LD_READY = ready;

  always_comb begin
    ld_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ld.LD_CH == CH_W'(i)) ld_sel[i] = accept;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    tick_gen_ch #(
      .DIV_W   (DIV_W),
      .RST_DIV (RST_DIV)
    ) u_ch (
      .clk_i    (PCK),
      .rst_i    (RST),
`ifdef MULTI_TICK_GEN_SYNC_EN
      .sync_i   (SYNC),
`endif
      .en_i     (EN[g]),
      .ld_i     (ld_sel[g]),
      .ld_div_i (ld.LD_DIV),
      .clk_o    (CLK_OUT[g]),
      .tick_o   (TICK[g]),
      .pend_o   (pend[g])
    );
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// tb_multi_tick_gen
//   Bench for multi_tick_gen with F_PCK=10, N_CH=4, DIV_W=8 (reset divisor 4).
//   Build with MULTI_TICK_GEN_SYNC_EN to also exercise SYNC.
module tb_multi_tick_gen;

  localparam int F_PCK = 10;
  localparam int N_CH  = 4;
  localparam int DIV_W = 8;

  // ---------------- clock / reset ----------------
  logic            PCK = 1'b0;
  logic            RST = 1'b1;
  logic [N_CH-1:0] EN  = '0;
`ifdef MULTI_TICK_GEN_SYNC_EN
  logic            SYNC = 1'b0;
`endif
  wire  [N_CH-1:0] CLK_OUT;
  wire  [N_CH-1:0] TICK;

  always #5 PCK = ~PCK;

  multi_tick_gen_if #(.N_CH(N_CH), .DIV_W(DIV_W)) ld_if ();

  multi_tick_gen #(.F_PCK(F_PCK), .N_CH(N_CH), .DIV_W(DIV_W)) dut (
    .PCK     (PCK),
    .RST     (RST),
`ifdef MULTI_TICK_GEN_SYNC_EN
    .SYNC    (SYNC),
`endif
    .EN      (EN),
    .ld      (ld_if.slave),
    .CLK_OUT (CLK_OUT),
    .TICK    (TICK)
  );

  // ---------------- scoreboard ----------------
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic rdy_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel is described by how many enabled cycles remain until its
  // next output edge, its current level, and an optional queued divisor.
  int m_div  [N_CH];
  int m_rem  [N_CH];
  int m_pdiv [N_CH];
  bit m_pend [N_CH];
  bit m_lvl  [N_CH];
  bit m_tick [N_CH];

  function automatic void model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_div[i]  = F_PCK / 2 - 1;
      m_rem[i]  = m_div[i] + 1;
      m_pdiv[i] = 0;
      m_pend[i] = 0;
      m_lvl[i]  = 0;
      m_tick[i] = 0;
    end
  endfunction

  function automatic void model_edge(input logic [N_CH-1:0] en_v, input bit acc,
                                     input int ch, input int dv,
                                     input bit rst_v, input bit sync_v);
    if (rst_v) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N_CH; i++) begin
      m_tick[i] = 0;
      if (sync_v) begin
        m_lvl[i] = 0;
        if (m_pend[i]) begin
          m_div[i]  = m_pdiv[i];
          m_pend[i] = 0;
        end
        m_rem[i] = m_div[i] + 1;
      end else if (en_v[i]) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_lvl[i]  = !m_lvl[i];
          m_tick[i] = m_lvl[i];
          if (m_pend[i]) begin
            m_div[i]  = m_pdiv[i];
            m_pend[i] = 0;
          end
          m_rem[i] = m_div[i] + 1;
        end
      end
    end
    if (acc) begin
      m_pdiv[ch] = dv;
      m_pend[ch] = 1;
    end
  endfunction

  function automatic logic [N_CH-1:0] m_clk_vec();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_lvl[i];
    return v;
  endfunction

  function automatic logic [N_CH-1:0] m_tick_vec();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_tick[i];
    return v;
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge: drive, check LD_READY, clock, check outputs.
  task automatic step(input logic [N_CH-1:0] en_v, input bit vld_v, input int ch_v,
                      input int dv_v, input bit rst_v, input bit sync_v);
    bit acc;
    bit sync_eff;
    sync_eff = 1'b0;
    RST             = rst_v;
    EN              = en_v;
    ld_if.LD_VALID  = vld_v;
    ld_if.LD_CH     = ch_v[1:0];
    ld_if.LD_DIV    = dv_v[DIV_W-1:0];
`ifdef MULTI_TICK_GEN_SYNC_EN
    SYNC     = sync_v;
    sync_eff = sync_v;
`endif
    #1;
    rdy_seen = ld_if.LD_READY;
    chk("ld_ready", {31'd0, ld_if.LD_READY}, {31'd0, !m_pend[ch_v]});
    acc = vld_v && !m_pend[ch_v];
    @(posedge PCK);
    model_edge(en_v, acc, ch_v, dv_v, rst_v, sync_eff);
    cyc++;
    #1;
    chk("clk_out", {28'd0, CLK_OUT}, {28'd0, m_clk_vec()});
    chk("tick", {28'd0, TICK}, {28'd0, m_tick_vec()});
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'hF, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int              n;
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] exp_clk;
    logic [N_CH-1:0] exp_tick;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [5:0] pat1;
    logic [7:0] pat2;
    logic [9:0] pat3;

    // After reset release: rise at 5, fall at 10, ticks at 5/15/25; then
    // EN[3] low for cycles 26..32 delays channel 3 by exactly 7 cycles.
    tbl[0] = '{4,  4'hF, 4'h0, 4'h0};   // cyc 4
    tbl[1] = '{1,  4'hF, 4'hF, 4'hF};   // cyc 5
    tbl[2] = '{1,  4'hF, 4'hF, 4'h0};   // cyc 6
    tbl[3] = '{4,  4'hF, 4'h0, 4'h0};   // cyc 10
    tbl[4] = '{5,  4'hF, 4'hF, 4'hF};   // cyc 15
    tbl[5] = '{10, 4'hF, 4'hF, 4'hF};   // cyc 25
    tbl[6] = '{7,  4'h7, 4'h8, 4'h0};   // cyc 32, ch3 frozen high
    tbl[7] = '{3,  4'hF, 4'hF, 4'h7};   // cyc 35
    tbl[8] = '{2,  4'hF, 4'h7, 4'h0};   // cyc 37, ch3 falls
    tbl[9] = '{5,  4'hF, 4'h8, 4'h8};   // cyc 42, ch3 rises

    model_reset();
    ld_if.LD_VALID = 1'b0;
    ld_if.LD_CH    = '0;
    ld_if.LD_DIV   = '0;

    repeat (3) step(4'h0, 1'b0, 0, 0, 1'b1, 1'b0);
    chk("rst_clk", {28'd0, CLK_OUT}, 32'd0);
    chk("rst_tick", {28'd0, TICK}, 32'd0);
    chk("rst_ready", {31'd0, rdy_seen}, 32'd1);
    cyc = 0;

    for (int r = 0; r < 10; r++) begin
      repeat (tbl[r].n) step(tbl[r].en, 1'b0, 0, 0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_clk", r), {28'd0, CLK_OUT}, {28'd0, tbl[r].exp_clk});
      chk($sformatf("tbl%0d_tick", r), {28'd0, TICK}, {28'd0, tbl[r].exp_tick});
    end

    // ch1 -> divisor 1 mid half-period (accepted at 43, applied at 45).
    step(4'hF, 1'b1, 1, 1, 1'b0, 1'b0);
    chk("ld1_accept_ready", {31'd0, rdy_seen}, 32'd1);
    step(4'hF, 1'b1, 1, 3, 1'b0, 1'b0);
    chk("ld1_stall", {31'd0, rdy_seen}, 32'd0);
    step(4'hF, 1'b0, 1, 0, 1'b0, 1'b0);
    chk("ld1_pending", {31'd0, rdy_seen}, 32'd0);
    chk("ld1_rise45", {31'd0, CLK_OUT[1]}, 32'd1);
    step(4'hF, 1'b0, 1, 0, 1'b0, 1'b0);
    chk("ld1_ready_back", {31'd0, rdy_seen}, 32'd1);
    pat1 = 6'b001100;  // cycles 47..52
    for (int k = 0; k < 6; k++) begin
      step(4'hF, 1'b0, 1, 0, 1'b0, 1'b0);
      chk($sformatf("ld1_period4_k%0d", k), {31'd0, CLK_OUT[1]}, {31'd0, pat1[k]});
    end

    // ch2: accept coincides with its terminal count at 55.
    idle(2);
    step(4'hF, 1'b1, 2, 1, 1'b0, 1'b0);
    chk("ld2_accept_ready", {31'd0, rdy_seen}, 32'd1);
    chk("ld2_tc_tick", {31'd0, TICK[2]}, 32'd1);
    step(4'hF, 1'b1, 2, 3, 1'b0, 1'b0);
    chk("ld2_stall", {31'd0, rdy_seen}, 32'd0);
    pat2 = 8'b01100111;  // cycles 57..64: old half-period ends at 60
    for (int k = 0; k < 8; k++) begin
      step(4'hF, 1'b0, 2, 0, 1'b0, 1'b0);
      chk($sformatf("ld2_k%0d", k), {31'd0, CLK_OUT[2]}, {31'd0, pat2[k]});
    end

    // Reset while ch0 is high and has a pending divisor.
    idle(1);
    chk("ch0_high65", {31'd0, CLK_OUT[0]}, 32'd1);
    step(4'hF, 1'b1, 0, 2, 1'b0, 1'b0);
    step(4'hF, 1'b0, 0, 0, 1'b1, 1'b0);
    chk("rstpulse_clk", {28'd0, CLK_OUT}, 32'd0);
    chk("rstpulse_tick", {28'd0, TICK}, 32'd0);
    pat3 = 10'b0111110000;  // 5 low, 5 high, then low: divisor back to 4
    for (int k = 0; k < 10; k++) begin
      step(4'hF, 1'b0, 0, 0, 1'b0, 1'b0);
      if (k == 0) chk("rstpulse_ready", {31'd0, rdy_seen}, 32'd1);
      chk($sformatf("rstpulse_k%0d", k), {31'd0, CLK_OUT[0]}, {31'd0, pat3[k]});
    end

`ifdef MULTI_TICK_GEN_SYNC_EN
    // ch1 queued to divisor 2, then SYNC applies it and aligns phases.
    step(4'hF, 1'b1, 1, 2, 1'b0, 1'b0);
    step(4'hF, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("sync_clk", {28'd0, CLK_OUT}, 32'd0);
    chk("sync_tick", {28'd0, TICK}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step(4'hF, 1'b0, 1, 0, 1'b0, 1'b0);
      chk($sformatf("sync_ch0_k%0d", k), {31'd0, CLK_OUT[0]}, {31'd0, (k >= 5)});
      chk($sformatf("sync_ch1_k%0d", k), {31'd0, CLK_OUT[1]}, {31'd0, (k >= 3)});
    end
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [N_CH-1:0] en_r;
      bit              sync_r;
      for (int i = 0; i < N_CH; i++) en_r[i] = ($urandom_range(0, 7) != 0);
      sync_r = 1'b0;
`ifdef MULTI_TICK_GEN_SYNC_EN
      sync_r = ($urandom_range(0, 149) == 0);
`endif
      step(en_r, ($urandom_range(0, 3) == 0), int'($urandom_range(0, N_CH - 1)),
           int'($urandom_range(0, 6)), ($urandom_range(0, 299) == 0), sync_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_tick_gen.md
MULTI_TICK_GEN -- requirements
Module: multi_tick_gen

Interface
REQ-001 SHALL have parameter F_PCK, default 25174825, meaning PCK frequency in Hz.
REQ-002 SHALL have parameter N_CH, default 4, meaning number of independent output channels (1..16).
REQ-003 SHALL have parameter DIV_W, default 32, meaning divisor width in bits; DIV_W SHALL be at least $clog2(F_PCK/2).
REQ-004 SHALL have port PCK  input  1  pixel/system clock, all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port EN  input  N_CH  per-channel run enable.
REQ-007 SHALL have port LD_VALID  input  1  divisor-update request.
REQ-008 SHALL have port LD_READY  output  1  update accepted when LD_VALID and LD_READY are both high.
REQ-009 SHALL have port LD_CH  input  max(1,$clog2(N_CH))  target channel of the update.
REQ-010 SHALL have port LD_DIV  input  DIV_W  new half-period count minus 1.
REQ-011 SHALL have port CLK_OUT  output  N_CH  per-channel 50% square wave.
REQ-012 SHALL have port TICK  output  N_CH  one-PCK-cycle pulse per channel at each CLK_OUT rising edge.

Function
REQ-013 Each channel SHALL hold an active divisor D, a pending divisor P with pending flag F, and a counter C of DIV_W bits.
REQ-014 While EN[i] is high, C SHALL increment by 1 per cycle; when C equals D, the channel SHALL set C to 0 and toggle CLK_OUT[i] on the same edge.
REQ-015 Half period SHALL be D+1 PCK cycles and full period 2*(D+1); D=0 SHALL give PCK/2.
REQ-016 TICK[i] SHALL be high for exactly the cycle in which registered CLK_OUT[i] is newly 1, i.e. zero latency relative to CLK_OUT.
REQ-017 While EN[i] is low, C, CLK_OUT[i] and F SHALL hold, TICK[i] SHALL be 0, and counting SHALL resume from the held C when EN[i] returns high.
REQ-018 LD_READY SHALL be combinationally low when LD_CH < N_CH and F of channel LD_CH is set; otherwise it SHALL be high.
REQ-019 On an accepted update, P SHALL load LD_DIV and F SHALL set; LD_CH >= N_CH SHALL be accepted and discarded.
REQ-020 The pending value SHALL be applied only at the channel's next terminal count occurring after acceptance (D<=P, F cleared, C<=0), so no shortened half-period is ever produced.
REQ-021 An accept and a terminal count in the same cycle SHALL NOT apply P in that cycle; the old D SHALL complete one more half-period.
REQ-022 Counter arithmetic SHALL wrap modulo 2^DIV_W; if C>D arises, C SHALL count through wrap to D without any special case.

Reset
REQ-023 On RST, every D SHALL load F_PCK/2-1 (1 Hz default), C SHALL be 0, F SHALL be 0, CLK_OUT SHALL be 0, and TICK SHALL be 0.
REQ-024 RST SHALL override EN, LD_VALID and a terminal count in the same cycle; pending updates SHALL be discarded.
REQ-025 Register initial values SHALL equal reset values.

Configuration
REQ-026 With MULTI_TICK_GEN_SYNC_EN defined, the module SHALL add port SYNC input 1; a SYNC pulse SHALL set all C to 0 and CLK_OUT to 0 and apply any pending P, phase-aligning all channels; TICK SHALL be 0 that cycle; RST SHALL have priority over SYNC.
REQ-027 Without MULTI_TICK_GEN_SYNC_EN, port SYNC and its logic SHALL be absent and channels SHALL be phase-independent.

Structure
REQ-028 Package multi_tick_gen_pkg SHALL hold the F_PCK and DIV_W default constants and a constant function half_div(f_pck, f_out) returning f_pck/(2*f_out)-1.
REQ-029 One channel (C, D, P, F, toggle, TICK) SHALL be sub-module tick_gen_ch, instantiated N_CH times by generate; the top SHALL hold only load decode and LD_READY.

Verification (F_PCK=10, N_CH=4, DIV_W=8)
REQ-030 Reset release, all EN=1 -> every CLK_OUT rises at cycle 5 and falls at 10, period 10; TICK pulses at cycles 5, 15, 25.
REQ-031 Load ch1 LD_DIV=1 mid half-period -> LD_READY for ch1 low until the next ch1 terminal count; period 4 thereafter; no half-period shorter than 2.
REQ-032 Accept coincident with terminal count on ch2 -> one more half-period of 5, then new divisor; second LD_VALID on ch2 while pending is stalled.
REQ-033 EN[3] low for 7 cycles mid-count -> CLK_OUT[3] frozen, no TICK; phase shifted exactly 7 cycles versus ch0.
REQ-034 RST pulse while ch0 has a pending update and CLK_OUT=1 -> all outputs 0, D back to 4, pending lost, LD_READY high.
REQ-035 With MULTI_TICK_GEN_SYNC_EN, channels at divisors 4 and 2, SYNC pulse -> both CLK_OUT 0 and coincident rising edges at 5 and 3 cycles after it.
